fir_feeder: RTL and testbench

FIR_FEEDER -- requirements
Module: fir_feeder

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_sample_fifo.sv | 61 ++++++
 rtl/fir_feeder.sv | 123 ++++++++++++
 tb/tb_fir_feeder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, feeder FSM states and the result
// scaling helper used where accumulator values are narrowed to sample width.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_ACC_W  = 38;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

  // Round half up, arithmetic shift, then clamp to the signed range of i_data_w.
  // The 64-bit datapath cannot overflow for accumulators up to 62 bits wide.
  function automatic logic signed [63:0] fir_scale_sat(
    input logic signed [63:0] i_acc,
    input int                 i_shift,
    input int                 i_data_w
  );
    logic signed [63:0] t;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = i_acc + (64'sd1 <<< (i_shift - 1));
    r  = t >>> i_shift;
    hi = (64'sd1 <<< (i_data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (i_data_w - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Power-of-two sample FIFO with a registered occupancy count.
// A push while full is dropped even when a pop happens in the same cycle.
module fir_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately left out of reset; the count alone marks
  // entries valid, and a reset-free array maps onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_feeder.sv
// Buffers upstream samples and feeds them one at a time to a FIR, waiting for
// each result (with timeout), then presents the scaled result downstream.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_W,
  parameter int OUT_WIDTH  = FIR_ACC_W,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT      = 15,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] fir_in,
  output logic                  fir_input_valid,
  input  logic [OUT_WIDTH-1:0]  fir_out,
  input  logic                  fir_output_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  timeout_err
);

  localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  fir_state_e            r_state;
  logic                  r_ready_en;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_fir_in;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_timeout_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head;
  logic [63:0]           w_acc_ext;

  // s_ready stays low through reset and rises on the first edge after it.
  assign s_ready   = r_ready_en && !w_full;
  assign w_push    = s_valid && s_ready;
  assign w_pop     = (r_state == ST_ISSUE);
  assign w_acc_ext = {{(64 - OUT_WIDTH){fir_out[OUT_WIDTH-1]}}, fir_out};

  fir_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // fir_in is loaded on the way into ISSUE so it is valid for the whole pulse
  // and then holds until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_fir_in      <= '0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_fir_in <= w_head;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (fir_output_valid) begin
            r_m_data  <= DATA_WIDTH'(fir_scale_sat(w_acc_ext, SHIFT, DATA_WIDTH));
            r_m_valid <= 1'b1;
            r_state   <= ST_DRAIN;
          end else if (r_wait_cnt == WAIT_LIMIT) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fir_in          = r_fir_in;
  assign fir_input_valid = (r_state == ST_ISSUE);
  assign m_data          = r_m_data;
  assign m_valid         = r_m_valid;
  assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_fir_feeder.sv
// Self-checking bench for fir_feeder: table of scaling vectors plus hand-built
// sequences for latency, back-pressure, FIFO fill, timeout and reset.
module tb_fir_feeder;

  logic        clk;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] fir_in;
  logic        fir_input_valid;
  logic [37:0] fir_out;
  logic        fir_output_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        timeout_err;

  typedef struct {
    logic [15:0] sample;
    logic [37:0] acc;
    logic [15:0] exp;
    int          delay;
  } vec_t;

  vec_t        vecs[14];
  int          total;
  int          bad;
  longint      cyc;
  logic [15:0] exp_q[$];
  logic [15:0] issued_q[$];
  longint      issue_cyc[$];
  int          stub_delay_q[$];
  logic [37:0] stub_val_q[$];
  bit          spurious;

  fir_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .fir_in           (fir_in),
    .fir_input_valid  (fir_input_valid),
    .fir_out          (fir_out),
    .fir_output_valid (fir_output_valid),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] acc_of(input logic [15:0] s);
    return {7'd0, s, 15'd0};
  endfunction

  // Delay 0 means the stub never answers that issue.
  task automatic expect_op(input logic [37:0] acc, input int delay, input logic [15:0] exp);
    stub_val_q.push_back(acc);
    stub_delay_q.push_back(delay);
    if (delay > 0) exp_q.push_back(exp);
  endtask

  task automatic push(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 300 && !s_ready; i++) @(negedge clk);
    check("push_accept", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_issue(input int max);
    for (int i = 0; i < max && !fir_input_valid; i++) @(negedge clk);
    check("issue_seen", 64'(fir_input_valid), 64'd1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // FIR stub: records each issue, answers after the queued delay.
  initial begin : stub
    int          cnt;
    bit          pending;
    logic [37:0] val;
    cnt              = 0;
    pending          = 1'b0;
    val              = '0;
    fir_out          = '0;
    fir_output_valid = 1'b0;
    forever begin
      @(negedge clk);
      fir_output_valid = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (spurious) begin
        spurious         = 1'b0;
        fir_out          = 38'h0000100000;
        fir_output_valid = 1'b1;
      end else if (fir_input_valid) begin
        issued_q.push_back(fir_in);
        issue_cyc.push_back(cyc);
        cnt     = (stub_delay_q.size() > 0) ? stub_delay_q.pop_front() : 0;
        val     = (stub_val_q.size() > 0) ? stub_val_q.pop_front() : '0;
        pending = (cnt > 0);
      end else if (pending) begin
        if (cnt <= 1) begin
          fir_out          = val;
          fir_output_valid = 1'b1;
          pending          = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Scoreboard: compare every completed downstream handshake.
  initial begin : scoreboard
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && m_valid && m_ready) begin
        check("sb_expected_present", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_m_data", 64'(m_data), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] d;
    bit          ok;
    int          acc;
    total    = 0;
    bad      = 0;
    spurious = 1'b0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;

    vecs[0]  = '{16'h0125, 38'h0000008000, 16'h0001, 131};
    vecs[1]  = '{16'h0002, 38'h0040000000, 16'h7FFF, 3};
    vecs[2]  = '{16'h0003, 38'h2000000000, 16'h8000, 3};
    vecs[3]  = '{16'h0004, 38'h0000000000, 16'h0000, 1};
    vecs[4]  = '{16'h0005, 38'h0000004000, 16'h0001, 2};
    vecs[5]  = '{16'h0006, 38'h0000003FFF, 16'h0000, 2};
    vecs[6]  = '{16'h0007, 38'h3FFFFFC000, 16'h0000, 2};
    vecs[7]  = '{16'h0008, 38'h3FFFFFBFFF, 16'hFFFF, 2};
    vecs[8]  = '{16'h0009, 38'h003FFFBFFF, 16'h7FFF, 2};
    vecs[9]  = '{16'h000A, 38'h003FFFC000, 16'h7FFF, 2};
    vecs[10] = '{16'h000B, 38'h3FC0000000, 16'h8000, 2};
    vecs[11] = '{16'h000C, 38'h3FBFFF8000, 16'h8000, 2};
    vecs[12] = '{16'h000D, 38'h0000123456, 16'h0024, 2};
    vecs[13] = '{16'hFFFF, 38'h1FFFFFFFFF, 16'h7FFF, 5};

    // Reset state, asynchronous while rst is high.
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_fir_valid", 64'(fir_input_valid), 64'd0);
    check("rst_fir_in", 64'(fir_in), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(s_ready), 64'd1);

    // A result pulse while idle must be ignored.
    spurious = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m_valid) ok = 1'b0;
    end
    check("spurious_ignored", 64'(ok), 64'd1);
    check("spurious_m_data", 64'(m_data), 64'd0);

    // Scaling vectors, each from idle with an empty FIFO.
    for (int i = 0; i < 14; i++) begin
      expect_op(vecs[i].acc, vecs[i].delay, vecs[i].exp);
      push(vecs[i].sample);
      check("issue_not_first_edge", 64'(fir_input_valid), 64'd0);
      @(negedge clk);
      check("issue_second_edge", 64'(fir_input_valid), 64'd1);
      check("issue_fir_in", 64'(fir_in), 64'(vecs[i].sample));
      wait_drain(400);
      check("fir_in_hold", 64'(fir_in), 64'(vecs[i].sample));
    end

    // Back-to-back issue spacing with a one-cycle FIR and m_ready high.
    issue_cyc.delete();
    for (int i = 0; i < 3; i++) expect_op(acc_of(16'h0041 + 16'(i)), 1, 16'h0041 + 16'(i));
    for (int i = 0; i < 3; i++) push(16'h0041 + 16'(i));
    wait_drain(60);
    check("spacing_count", 64'(issue_cyc.size()), 64'd3);
    if (issue_cyc.size() == 3) begin
      check("spacing_1", 64'(issue_cyc[1] - issue_cyc[0]), 64'd4);
      check("spacing_2", 64'(issue_cyc[2] - issue_cyc[1]), 64'd4);
    end

    // Fill the FIFO behind a stalled FIR operation.
    issued_q.delete();
    expect_op(acc_of(16'h0050), 40, 16'h0050);
    for (int v = 1; v <= 8; v++) expect_op(acc_of(16'(v)), 2, 16'(v));
    push(16'h0050);
    wait_issue(5);
    repeat (2) @(negedge clk);
    acc     = 0;
    s_data  = 16'd1;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ok = s_ready;
      @(negedge clk);
      if (ok) begin
        acc++;
        s_data = 16'(acc + 1);
      end
    end
    check("fill_accepted", 64'(acc), 64'd8);
    check("fill_ready_low", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    wait_drain(300);
    check("fill_issued_count", 64'(issued_q.size()), 64'd9);
    if (issued_q.size() == 9) begin
      check("fill_order_0", 64'(issued_q[0]), 64'h50);
      for (int v = 1; v <= 8; v++) check("fill_order", 64'(issued_q[v]), 64'(v));
    end

    // Downstream back-pressure: result held, nothing new issued.
    m_ready = 1'b0;
    expect_op(acc_of(16'h0011), 1, 16'h0011);
    expect_op(acc_of(16'h0012), 1, 16'h0012);
    push(16'h0011);
    push(16'h0012);
    for (int i = 0; i < 20 && !m_valid; i++) @(negedge clk);
    check("hold_m_valid_seen", 64'(m_valid), 64'd1);
    d  = m_data;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!m_valid || m_data !== d || fir_input_valid) ok = 1'b0;
    end
    check("hold_stable", 64'(ok), 64'd1);
    check("hold_data", 64'(d), 64'h11);
    m_ready = 1'b1;
    wait_drain(50);

    // FIR never answers: timeout, no result, next sample issued.
    issued_q.delete();
    expect_op(acc_of(16'h0061), 0, 16'h0000);
    expect_op(acc_of(16'h0062), 1, 16'h0062);
    push(16'h0061);
    push(16'h0062);
    wait_issue(5);
    check("to_first_issue", 64'(fir_in), 64'h61);
    ok = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      if (k <= 256 && (m_valid || fir_input_valid)) ok = 1'b0;
      if (k == 256) check("timeout_not_yet", 64'(timeout_err), 64'd0);
      if (k == 257) check("timeout_set", 64'(timeout_err), 64'd1);
    end
    check("timeout_quiet", 64'(ok), 64'd1);
    check("timeout_no_m_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("timeout_next_issue", 64'(fir_input_valid), 64'd1);
    check("timeout_next_fir_in", 64'(fir_in), 64'h62);
    wait_drain(50);
    check("timeout_sticky", 64'(timeout_err), 64'd1);

    // Reset while waiting with three samples queued.
    expect_op(acc_of(16'h0070), 0, 16'h0000);
    for (int i = 1; i <= 3; i++) expect_op(acc_of(16'h0070 + 16'(i)), 1, 16'h0070 + 16'(i));
    push(16'h0070);
    push(16'h0071);
    push(16'h0072);
    push(16'h0073);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    stub_val_q.delete();
    stub_delay_q.delete();
    #1;
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_fir_valid", 64'(fir_input_valid), 64'd0);
    check("mid_rst_fir_in", 64'(fir_in), 64'd0);
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_m_data", 64'(m_data), 64'd0);
    check("mid_rst_timeout", 64'(timeout_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ok  = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (m_valid || fir_input_valid) ok = 1'b0;
    end
    check("post_rst_quiet", 64'(ok), 64'd1);

    // Normal operation resumes after reset.
    expect_op(acc_of(16'h0031), 1, 16'h0031);
    push(16'h0031);
    wait_drain(50);
    check("post_rst_fir_in", 64'(fir_in), 64'h31);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
